// File: rtl/ram_responder.sv
// 256 x 4-bit data-memory slave on the CPU RAM bus with programmable wait states and one I/O-mapped address.
// Optional: define RAM_CLEAR_EN to zero the whole storage after every reset before accepting requests.
module ram_responder #(
  parameter int                DATA_W      = 4,
  parameter int                ADDR_W      = 8,
  parameter int                WAIT_STATES = 1,
  parameter logic [ADDR_W-1:0] IO_ADDR     = 8'hFF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ram_RW,
  input  logic              ram_EN,
  input  logic [ADDR_W-1:0] ram_address_bus,
  input  logic [DATA_W-1:0] ram_data_bus_out,
  output logic [DATA_W-1:0] ram_data_bus_in,
  output logic              ram_ready,
  output logic              ram_busy,
  output logic              ram_err,
  input  logic [DATA_W-1:0] io_in,
  output logic [DATA_W-1:0] io_out
);

  localparam int         DEPTH   = 1 << ADDR_W;
  localparam logic [3:0] WS_INIT = 4'(WAIT_STATES);

`ifdef RAM_CLEAR_EN
  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DONE, S_CLEAR} state_t;
  localparam state_t S_RESET = S_CLEAR;
`else
  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DONE} state_t;
  localparam state_t S_RESET = S_IDLE;
`endif

  state_t            state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              rw_q, rw_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] io_cap_q, io_cap_d;
  logic              err_q, err_d;
  logic [DATA_W-1:0] io_out_q, io_out_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
`ifdef RAM_CLEAR_EN
  logic [ADDR_W-1:0] clr_addr_q, clr_addr_d;
`endif

  logic [DATA_W-1:0] mem [DEPTH];
  logic [DATA_W-1:0] mem_rd_q;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_waddr;
  logic [DATA_W-1:0] mem_wdata;
  logic [ADDR_W-1:0] rd_addr;
  logic              io_hit;
  logic [DATA_W-1:0] rd_sel;

  // The registered read is steered to the bus address while idle so that a
  // zero-wait-state read already has its word when DONE is entered.
  assign rd_addr = (state_q == S_IDLE) ? ram_address_bus : addr_q;
  assign io_hit  = (addr_q == IO_ADDR);
  assign rd_sel  = io_hit ? io_cap_q : mem_rd_q;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    addr_d    = addr_q;
    rw_d      = rw_q;
    wdata_d   = wdata_q;
    io_cap_d  = io_cap_q;
    err_d     = err_q;
    io_out_d  = io_out_q;
    rdata_d   = rdata_q;
    mem_we    = 1'b0;
    mem_waddr = addr_q;
    mem_wdata = wdata_q;
`ifdef RAM_CLEAR_EN
    clr_addr_d = clr_addr_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (ram_EN) begin
          addr_d  = ram_address_bus;
          rw_d    = ram_RW;
          wdata_d = ram_data_bus_out;
          if (!ram_RW && (ram_address_bus == IO_ADDR)) io_cap_d = io_in;
          cnt_d   = WS_INIT;
          state_d = (WAIT_STATES == 0) ? S_DONE : S_WAIT;
        end
      end
      S_WAIT: begin
        if (ram_EN) err_d = 1'b1;
        cnt_d = cnt_q - 4'd1;
        if (cnt_q <= 4'd1) state_d = S_DONE;
      end
      S_DONE: begin
        if (ram_EN) err_d = 1'b1;
        if (rw_q) begin
          mem_we = !io_hit;
        end else begin
          rdata_d = rd_sel;
        end
        state_d = S_IDLE;
      end
`ifdef RAM_CLEAR_EN
      S_CLEAR: begin
        if (ram_EN) err_d = 1'b1;
        mem_we     = 1'b1;
        mem_waddr  = clr_addr_q;
        mem_wdata  = '0;
        clr_addr_d = clr_addr_q + 1'b1;
        if (clr_addr_q == {ADDR_W{1'b1}}) state_d = S_IDLE;
      end
`endif
      default: state_d = S_IDLE;
    endcase
    // io_out is updated on entry to DONE so it is already valid while ram_ready is high.
    if ((state_d == S_DONE) && rw_d && (addr_d == IO_ADDR)) io_out_d = wdata_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_RESET;
      cnt_q    <= '0;
      addr_q   <= '0;
      rw_q     <= 1'b0;
      wdata_q  <= '0;
      io_cap_q <= '0;
      err_q    <= 1'b0;
      io_out_q <= '0;
      rdata_q  <= '0;
`ifdef RAM_CLEAR_EN
      clr_addr_q <= '0;
`endif
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      addr_q   <= addr_d;
      rw_q     <= rw_d;
      wdata_q  <= wdata_d;
      io_cap_q <= io_cap_d;
      err_q    <= err_d;
      io_out_q <= io_out_d;
      rdata_q  <= rdata_d;
`ifdef RAM_CLEAR_EN
      clr_addr_q <= clr_addr_d;
`endif
    end
  end

  // Storage is intentionally outside the reset so it maps onto block RAM.
  always_ff @(posedge clk) begin
    if (mem_we) mem[mem_waddr] <= mem_wdata;
    mem_rd_q <= mem[rd_addr];
  end

  assign ram_data_bus_in = ((state_q == S_DONE) && !rw_q) ? rd_sel : rdata_q;
  assign ram_ready       = (state_q == S_DONE);
  assign ram_busy        = (state_q != S_IDLE);
  assign ram_err         = err_q;
  assign io_out          = io_out_q;

endmodule

// File: tb/tb_ram_responder.sv
// Bench for ram_responder: three instances (0, 1 and 3 wait states) driven with directed and
// random bus accesses and checked against a simple memory/IO model kept here.
module tb_ram_responder;

  logic       clk;
  logic       rst_n;
  logic       rw     [3];
  logic       en     [3];
  logic [7:0] addr   [3];
  logic [3:0] wd     [3];
  logic [3:0] rd     [3];
  logic       rdy    [3];
  logic       busy   [3];
  logic       err    [3];
  logic [3:0] io_in  [3];
  logic [3:0] io_out [3];

  int         ws_m     [3] = '{0, 1, 3};
  logic [3:0] mem_m    [3][256];
  bit         known_m  [3][256];
  logic [3:0] io_out_m [3];
  logic [3:0] rdata_m  [3];
  bit         err_m    [3];

  int n_cmp = 0;
  int n_bad = 0;

  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : g_dut
      localparam int WS = (gi == 0) ? 0 : ((gi == 1) ? 1 : 3);
      ram_responder #(.WAIT_STATES(WS)) u_dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .ram_RW           (rw[gi]),
        .ram_EN           (en[gi]),
        .ram_address_bus  (addr[gi]),
        .ram_data_bus_out (wd[gi]),
        .ram_data_bus_in  (rd[gi]),
        .ram_ready        (rdy[gi]),
        .ram_busy         (busy[gi]),
        .ram_err          (err[gi]),
        .io_in            (io_in[gi]),
        .io_out           (io_out[gi])
      );
    end
  endgenerate

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected $finish");
    $fatal(1, "watchdog expired");
  end

  function automatic string tg(input string s, input int k);
    return $sformatf("%s_u%0d", s, k);
  endfunction

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // One bus access on instance k; optionally raises a second strobe one cycle later,
  // which must be dropped and flag the error.
  task automatic access(input int k, input bit w, input logic [7:0] a, input logic [3:0] d,
                        input bit probe);
    int c;
    bit seen;
    logic [3:0] exp_rd;
    exp_rd = (a == 8'hFF) ? io_in[k] : mem_m[k][a];
    rw[k] = w; addr[k] = a; wd[k] = d; en[k] = 1'b1;
    c = 0;
    seen = 1'b0;
    while (!seen && c < 40) begin
      @(negedge clk);
      c++;
      if (c == 1) begin
        check_eq(tg("busy_in_flight", k), 32'(busy[k]), 32'd1);
        en[k] = probe;
        if (probe) begin
          addr[k] = a ^ 8'h01; wd[k] = ~d; rw[k] = 1'b1;
        end
      end else begin
        en[k] = 1'b0;
      end
      if (rdy[k]) seen = 1'b1;
    end
    check_eq(tg("ready_seen", k), 32'(seen), 32'd1);
    check_eq(tg("latency", k), 32'(c), 32'(ws_m[k] + 1));
    if (w) begin
      if (a == 8'hFF) begin
        io_out_m[k] = d;
        check_eq(tg("io_out_at_ready", k), 32'(io_out[k]), 32'(d));
      end else begin
        mem_m[k][a]   = d;
        known_m[k][a] = 1'b1;
      end
    end else begin
      check_eq(tg("read_data", k), 32'(rd[k]), 32'(exp_rd));
      rdata_m[k] = exp_rd;
    end
    if (probe) err_m[k] = 1'b1;
    @(negedge clk);
    en[k] = 1'b0;
    check_eq(tg("ready_pulse_end", k), 32'(rdy[k]), 32'd0);
    check_eq(tg("busy_after", k), 32'(busy[k]), 32'd0);
    check_eq(tg("err", k), 32'(err[k]), 32'(err_m[k]));
    check_eq(tg("io_out", k), 32'(io_out[k]), 32'(io_out_m[k]));
    check_eq(tg("read_hold", k), 32'(rd[k]), 32'(rdata_m[k]));
    $display("tx u%0d %s addr=%02h data=%h latency=%0d probe=%0d", k, w ? "WR" : "RD", a,
             w ? d : rd[k], c, probe);
  endtask

  // Asserts reset at the current point (possibly mid-access), checks the outputs
  // drop at once, then releases it and updates the model.
  task automatic do_reset();
    int cnt;
    rst_n = 1'b0;
    #1;
    for (int k = 0; k < 3; k++) begin
      check_eq(tg("rst_ready", k), 32'(rdy[k]), 32'd0);
      check_eq(tg("rst_err", k), 32'(err[k]), 32'd0);
      check_eq(tg("rst_io_out", k), 32'(io_out[k]), 32'd0);
      check_eq(tg("rst_rdata", k), 32'(rd[k]), 32'd0);
`ifndef RAM_CLEAR_EN
      check_eq(tg("rst_busy", k), 32'(busy[k]), 32'd0);
`endif
      en[k] = 1'b0;
      io_out_m[k] = '0;
      rdata_m[k]  = '0;
      err_m[k]    = 1'b0;
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
`ifdef RAM_CLEAR_EN
    rw[0] = 1'b0; addr[0] = 8'h7F; en[0] = 1'b1;
    #1;
    cnt = 0;
    while (busy[0] && cnt < 600) begin
      cnt++;
      @(negedge clk);
      en[0] = 1'b0;
    end
    check_eq("sweep_busy_cycles", 32'(cnt), 32'd256);
    err_m[0] = 1'b1;
    for (int k = 0; k < 3; k++) begin
      for (int a = 0; a < 256; a++) begin
        mem_m[k][a]   = '0;
        known_m[k][a] = 1'b1;
      end
      check_eq(tg("sweep_err", k), 32'(err[k]), 32'(err_m[k]));
    end
`else
    cnt = 0;
    @(negedge clk);
`endif
  endtask

  initial begin
    logic [7:0] a;
    logic [3:0] v;
    bit w;
    rst_n = 1'b0;
    for (int k = 0; k < 3; k++) begin
      rw[k] = 1'b0; en[k] = 1'b0; addr[k] = '0; wd[k] = '0; io_in[k] = '0;
      for (int i = 0; i < 256; i++) begin
        mem_m[k][i]   = '0;
        known_m[k][i] = 1'b0;
      end
    end
    @(negedge clk);
    do_reset();
`ifdef RAM_CLEAR_EN
    access(0, 1'b0, 8'h7F, 4'h0, 1'b0);
`endif

    access(1, 1'b1, 8'h10, 4'hA, 1'b0);
    access(1, 1'b0, 8'h10, 4'h0, 1'b0);
    access(0, 1'b1, 8'h00, 4'h3, 1'b0);
    access(0, 1'b1, 8'hFE, 4'hC, 1'b0);
    access(0, 1'b0, 8'h00, 4'h0, 1'b0);
    access(0, 1'b0, 8'hFE, 4'h0, 1'b0);
    access(1, 1'b1, 8'hFF, 4'h5, 1'b0);
    io_in[1] = 4'h9;
    access(1, 1'b0, 8'hFF, 4'h0, 1'b0);
    access(1, 1'b0, 8'h10, 4'h0, 1'b0);

    access(2, 1'b1, 8'h41, 4'h2, 1'b0);
    access(2, 1'b1, 8'h40, 4'h7, 1'b1);
    access(2, 1'b0, 8'h41, 4'h0, 1'b0);
    access(2, 1'b0, 8'h40, 4'h0, 1'b0);

    for (int k = 0; k < 3; k++) begin
      for (int t = 0; t < 30; t++) begin
        io_in[k] = 4'($urandom);
        w = 1'($urandom);
        if (w) begin
          case ($urandom_range(0, 7))
            0:       a = 8'hFF;
            1:       a = 8'h00;
            2:       a = 8'hFE;
            default: a = 8'($urandom);
          endcase
          access(k, 1'b1, a, 4'($urandom), 1'b0);
        end else begin
          a = 8'hFF;
          for (int tries = 0; tries < 20; tries++) begin
            v = 4'($urandom);
            a = 8'($urandom);
            if (known_m[k][a]) break;
            a = 8'hFF;
          end
          access(k, 1'b0, a, 4'h0, 1'b0);
        end
      end
    end

    access(2, 1'b1, 8'h20, 4'h6, 1'b0);
    rw[2] = 1'b1; addr[2] = 8'h20; wd[2] = 4'h9; en[2] = 1'b1;
    @(negedge clk);
    en[2] = 1'b0;
    do_reset();
    access(2, 1'b0, 8'h20, 4'h0, 1'b0);
    access(1, 1'b0, 8'h10, 4'h0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
